// File: rtl/bus_m2s3_interconnect_pkg.sv
// Shared types for the 2-master / 3-slave serial bus: slave ids, arbiter and decoder states.
// No logic here; the grant encoding is chosen so that the state register drives the grant pins directly.
package bus_m2s3_interconnect_pkg;

    localparam logic [1:0] SLV_ID_S1   = 2'd0;
    localparam logic [1:0] SLV_ID_S2   = 2'd1;
    localparam logic [1:0] SLV_ID_S3   = 2'd2;
    localparam logic [1:0] SLV_ID_RSVD = 2'd3;

    // Bit 0 is the m1 grant, bit 1 the m2 grant.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_M1   = 2'b01,
        ARB_M2   = 2'b10
    } arb_state_t;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_ADDR,
        DEC_CHECK,
        DEC_WAIT_RDY,
        DEC_CONNECT,
        DEC_INVALID
    } dec_state_t;

    function automatic int dev_addr_width(input int addr_w, input int mem_w);
        return addr_w - mem_w;
    endfunction

endpackage

// File: rtl/bus_m2s3_interconnect_decoder.sv
// Serial device-address decoder: shifts in the device field, checks it, waits for slave ready, selects and acks.
// Ack arrives two cycles after the last device bit when the slave is ready; a busy slave stalls the ack, never the bus.
module bus_addr_decoder
    import bus_m2s3_interconnect_pkg::*;
#(
    parameter int DEV_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       owner_active,
    input  logic       owner_wdata,
    input  logic       owner_mvalid,
    input  logic [2:0] slave_ready,
    output logic [2:0] slave_sel,
    output logic       ack
);

    localparam int CNT_W = $clog2(DEV_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEV_W - 1);

    dec_state_t       state;
    logic [DEV_W-1:0] dev_addr;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       slv_id;
    logic             addr_ok;
    logic [2:0]       id_onehot;
    logic             sel_ready;

    assign slv_id    = dev_addr[1:0];
    assign addr_ok   = ((dev_addr >> 2) == '0) && (slv_id != SLV_ID_RSVD);
    assign sel_ready = |(id_onehot & slave_ready);

    always_comb begin
        id_onehot = 3'b000;
        case (slv_id)
            SLV_ID_S1: id_onehot = 3'b001;
            SLV_ID_S2: id_onehot = 3'b010;
            SLV_ID_S3: id_onehot = 3'b100;
            default:   id_onehot = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DEC_IDLE;
            dev_addr  <= '0;
            bit_cnt   <= '0;
            slave_sel <= 3'b000;
            ack       <= 1'b0;
        end else begin
            ack <= 1'b0;
            // Owner releasing breq (or losing grant) ends the transaction from any state.
            if (!owner_active) begin
                state     <= DEC_IDLE;
                bit_cnt   <= '0;
                slave_sel <= 3'b000;
            end else begin
                case (state)
                    DEC_IDLE, DEC_ADDR: begin
                        state <= DEC_ADDR;
                        if (owner_mvalid) begin
                            dev_addr <= {owner_wdata, dev_addr[DEV_W-1:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_LAST) begin
                                state <= DEC_CHECK;
                            end
                        end
                    end
                    DEC_CHECK, DEC_WAIT_RDY: begin
                        if (!addr_ok) begin
                            state <= DEC_INVALID;
                        end else if (sel_ready) begin
                            state     <= DEC_CONNECT;
                            slave_sel <= id_onehot;
                            ack       <= 1'b1;
                        end else begin
                            state <= DEC_WAIT_RDY;
                        end
                    end
                    DEC_CONNECT, DEC_INVALID: state <= state;
                    default:                  state <= DEC_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/bus_m2s3_interconnect.sv
// Bit-serial 2-master / 3-slave interconnect: fixed-priority arbiter, address decoder, combinational data muxes.
// Grant one cycle after request; forwarding is zero-latency once connected; masters wait on grant/ack, slaves on ready.
module bus_m2s3_interconnect
    import bus_m2s3_interconnect_pkg::*;
#(
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic m1_wdata,
    input  logic m1_mode,
    input  logic m1_mvalid,
    input  logic m1_breq,
    output logic m1_bgrant,
    output logic m1_ack,
    output logic m1_rdata,
    output logic m1_svalid,
    input  logic m2_wdata,
    input  logic m2_mode,
    input  logic m2_mvalid,
    input  logic m2_breq,
    output logic m2_bgrant,
    output logic m2_ack,
    output logic m2_rdata,
    output logic m2_svalid,
    output logic s1_wdata,
    output logic s1_mode,
    output logic s1_mvalid,
    input  logic s1_rdata,
    input  logic s1_svalid,
    input  logic s1_ready,
    output logic s2_wdata,
    output logic s2_mode,
    output logic s2_mvalid,
    input  logic s2_rdata,
    input  logic s2_svalid,
    input  logic s2_ready,
    output logic s3_wdata,
    output logic s3_mode,
    output logic s3_mvalid,
    input  logic s3_rdata,
    input  logic s3_svalid,
    input  logic s3_ready
);

    localparam int DEVICE_ADDR_WIDTH = dev_addr_width(ADDR_WIDTH, SLAVE_MEM_ADDR_WIDTH);

    if (DEVICE_ADDR_WIDTH < 2 || DATA_WIDTH < 1) begin : g_param_check
        $error("bus_m2s3_interconnect: device field needs at least 2 bits and data at least 1 bit");
    end

    arb_state_t arb_state;
    logic       own_breq;
    logic       own_wdata;
    logic       own_mode;
    logic       own_mvalid;
    logic [2:0] slave_sel;
    logic       dec_ack;
    logic       sel_rdata;
    logic       sel_svalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state <= ARB_IDLE;
        end else begin
            case (arb_state)
                ARB_M1: if (!m1_breq) arb_state <= m2_breq ? ARB_M2 : ARB_IDLE;
                ARB_M2: if (!m2_breq) arb_state <= m1_breq ? ARB_M1 : ARB_IDLE;
                default: arb_state <= m1_breq ? ARB_M1 : (m2_breq ? ARB_M2 : ARB_IDLE);
            endcase
        end
    end

    assign {m2_bgrant, m1_bgrant} = arb_state;

    assign own_breq   = (m1_bgrant & m1_breq)   | (m2_bgrant & m2_breq);
    assign own_wdata  = (m1_bgrant & m1_wdata)  | (m2_bgrant & m2_wdata);
    assign own_mode   = (m1_bgrant & m1_mode)   | (m2_bgrant & m2_mode);
    assign own_mvalid = (m1_bgrant & m1_mvalid) | (m2_bgrant & m2_mvalid);

    bus_addr_decoder #(
        .DEV_W (DEVICE_ADDR_WIDTH)
    ) u_dec (
        .clk          (clk),
        .rst          (rst),
        .owner_active (own_breq),
        .owner_wdata  (own_wdata),
        .owner_mvalid (own_mvalid),
        .slave_ready  ({s3_ready, s2_ready, s1_ready}),
        .slave_sel    (slave_sel),
        .ack          (dec_ack)
    );

    // slave_sel is non-zero only while connected, so it alone gates the data paths.
    assign s1_wdata  = slave_sel[0] & own_wdata;
    assign s1_mode   = slave_sel[0] & own_mode;
    assign s1_mvalid = slave_sel[0] & own_mvalid;
    assign s2_wdata  = slave_sel[1] & own_wdata;
    assign s2_mode   = slave_sel[1] & own_mode;
    assign s2_mvalid = slave_sel[1] & own_mvalid;
    assign s3_wdata  = slave_sel[2] & own_wdata;
    assign s3_mode   = slave_sel[2] & own_mode;
    assign s3_mvalid = slave_sel[2] & own_mvalid;

    assign sel_rdata  = |(slave_sel & {s3_rdata, s2_rdata, s1_rdata});
    assign sel_svalid = |(slave_sel & {s3_svalid, s2_svalid, s1_svalid});

    assign m1_ack    = m1_bgrant & dec_ack;
    assign m1_rdata  = m1_bgrant & sel_rdata;
    assign m1_svalid = m1_bgrant & sel_svalid;
    assign m2_ack    = m2_bgrant & dec_ack;
    assign m2_rdata  = m2_bgrant & sel_rdata;
    assign m2_svalid = m2_bgrant & sel_svalid;

endmodule

// File: tb/tb_bus_m2s3_interconnect.sv
// Directed bench for bus_m2s3_interconnect with behavioural serial slaves and master transaction tasks.
module tb_bus_m2s3_interconnect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] m_wdata = '0;
    logic [1:0] m_mode = '0;
    logic [1:0] m_mvalid = '0;
    logic [1:0] m_breq = '0;
    wire  [1:0] m_bgrant, m_ack, m_rdata, m_svalid;
    wire  [2:0] s_wdata, s_mode, s_mvalid;
    logic [2:0] s_rdata;
    logic [2:0] s_svalid;
    logic [2:0] s_ready = 3'b111;

    typedef struct {
        logic [7:0] rd;
        int         nrd;
        bit         ack;
        int         q;
        int         g;
        int         d;
    } txn_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_cnt[2] = '{0, 0};
    int ack_cyc[2] = '{-1, -1};
    int sv_cnt[2]  = '{0, 0};
    int mv_cnt[3]  = '{0, 0, 0};
    logic [7:0] mem [3][4096];

    always #5 clk = ~clk;

    bus_m2s3_interconnect dut (
        .clk       (clk),        .rst       (rst),
        .m1_wdata  (m_wdata[0]), .m1_mode   (m_mode[0]),   .m1_mvalid (m_mvalid[0]), .m1_breq (m_breq[0]),
        .m1_bgrant (m_bgrant[0]),.m1_ack    (m_ack[0]),    .m1_rdata  (m_rdata[0]),  .m1_svalid (m_svalid[0]),
        .m2_wdata  (m_wdata[1]), .m2_mode   (m_mode[1]),   .m2_mvalid (m_mvalid[1]), .m2_breq (m_breq[1]),
        .m2_bgrant (m_bgrant[1]),.m2_ack    (m_ack[1]),    .m2_rdata  (m_rdata[1]),  .m2_svalid (m_svalid[1]),
        .s1_wdata  (s_wdata[0]), .s1_mode   (s_mode[0]),   .s1_mvalid (s_mvalid[0]),
        .s1_rdata  (s_rdata[0]), .s1_svalid (s_svalid[0]), .s1_ready  (s_ready[0]),
        .s2_wdata  (s_wdata[1]), .s2_mode   (s_mode[1]),   .s2_mvalid (s_mvalid[1]),
        .s2_rdata  (s_rdata[1]), .s2_svalid (s_svalid[1]), .s2_ready  (s_ready[1]),
        .s3_wdata  (s_wdata[2]), .s3_mode   (s_mode[2]),   .s3_mvalid (s_mvalid[2]),
        .s3_rdata  (s_rdata[2]), .s3_svalid (s_svalid[2]), .s3_ready  (s_ready[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (m_ack[m]) begin
                ack_cnt[m] <= ack_cnt[m] + 1;
                ack_cyc[m] <= cyc;
            end
            if (m_svalid[m]) sv_cnt[m] <= sv_cnt[m] + 1;
        end
        for (int k = 0; k < 3; k++) begin
            if (s_mvalid[k]) mv_cnt[k] <= mv_cnt[k] + 1;
        end
    end

    // Serial slaves: 12 address bits then 8 write bits, or 8 read bits returned after the address.
    initial begin
        int         sl_cnt[3];
        int         sl_left[3];
        logic       sl_mode[3];
        logic [11:0] sl_addr[3];
        logic [7:0] sl_data[3];
        logic [7:0] sl_rword[3];
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 4096; a++) mem[k][a] = 8'h00;
            sl_cnt[k] = 0; sl_left[k] = 0; sl_mode[k] = 1'b0;
            sl_addr[k] = '0; sl_data[k] = '0; sl_rword[k] = '0;
        end
        mem[0][12'h010] = 8'h3C;
        mem[2][12'h020] = 8'hC3;
        s_rdata  = 3'b000;
        s_svalid = 3'b000;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    sl_cnt[k]  = 0;
                    sl_left[k] = 0;
                end else if (s_mvalid[k]) begin
                    if (sl_cnt[k] == 0) sl_mode[k] = s_mode[k];
                    if (sl_cnt[k] < 12) sl_addr[k][sl_cnt[k]] = s_wdata[k];
                    else                sl_data[k][sl_cnt[k] - 12] = s_wdata[k];
                    sl_cnt[k]++;
                    if (!sl_mode[k] && sl_cnt[k] == 12) begin
                        sl_rword[k] = mem[k][sl_addr[k]];
                        sl_left[k]  = 8;
                        sl_cnt[k]   = 0;
                    end else if (sl_mode[k] && sl_cnt[k] == 20) begin
                        mem[k][sl_addr[k]] = sl_data[k];
                        sl_cnt[k] = 0;
                    end
                end
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                if (sl_left[k] > 0) begin
                    s_svalid[k] = 1'b1;
                    s_rdata[k]  = sl_rword[k][0];
                    sl_rword[k] = sl_rword[k] >> 1;
                    sl_left[k]--;
                end else begin
                    s_svalid[k] = 1'b0;
                    s_rdata[k]  = 1'b0;
                end
            end
        end
    end

    task automatic master_txn(input int m, input logic [15:0] addr, input bit wr,
                              input logic [7:0] wd, input int ack_tmo, output txn_t r);
        int n;
        r.rd = '0; r.nrd = 0; r.ack = 1'b0; r.q = -1; r.g = -1; r.d = -1;
        @(posedge clk); #1;
        m_breq[m] = 1'b1;
        m_mode[m] = wr;
        r.q = cyc;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m_bgrant[m] && n < 200);
        if (m_bgrant[m]) begin
            r.g = cyc;
            for (int i = 0; i < 4; i++) begin
                m_wdata[m]  = addr[12 + i];
                m_mvalid[m] = 1'b1;
                if (i < 3) begin @(posedge clk); #1; end
            end
            n = 0;
            do begin
                @(posedge clk); #1;
                m_mvalid[m] = 1'b0;
                m_wdata[m]  = 1'b0;
                n++;
            end while (!m_ack[m] && n < ack_tmo);
            r.ack = m_ack[m];
            if (r.ack) begin
                for (int i = 0; i < 12; i++) begin
                    m_wdata[m] = addr[i]; m_mvalid[m] = 1'b1;
                    @(posedge clk); #1;
                end
                if (wr) begin
                    for (int i = 0; i < 8; i++) begin
                        m_wdata[m] = wd[i]; m_mvalid[m] = 1'b1;
                        @(posedge clk); #1;
                    end
                end
                m_mvalid[m] = 1'b0;
                m_wdata[m]  = 1'b0;
                if (!wr) begin
                    n = 0;
                    while (r.nrd < 8 && n < 30) begin
                        @(negedge clk);
                        if (m_svalid[m]) begin
                            r.rd[r.nrd] = m_rdata[m];
                            r.nrd++;
                        end
                        n++;
                    end
                    @(posedge clk); #1;
                end
            end
        end
        m_breq[m]   = 1'b0;
        m_mode[m]   = 1'b0;
        m_mvalid[m] = 1'b0;
        m_wdata[m]  = 1'b0;
        r.d = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t r1, r2;
        logic [1:0] seen;
        int b_ack[2], b_sv, b_mv[3], sv_mid, mv_mid, rise_cyc;

        // Reset with all master inputs active: outputs must stay quiet.
        m_breq = 2'b11; m_wdata = 2'b11; m_mvalid = 2'b11; m_mode = 2'b11;
        #2;
        check_eq("reset_outputs", {m_bgrant, m_ack, m_rdata, m_svalid, s_wdata, s_mode, s_mvalid}, 0);
        @(posedge clk); #1;
        check_eq("reset_hold_grant", m_bgrant, 0);
        m_breq = '0; m_wdata = '0; m_mvalid = '0; m_mode = '0;
        rst = 1'b0;
        seen = '0;
        repeat (10) begin @(posedge clk); #1; seen |= m_bgrant; end
        check_eq("idle_no_grant", seen, 0);

        // m1 write 0xA5 to 0x1234 (slave 2, location 0x234).
        b_ack = ack_cnt; b_mv = mv_cnt;
        master_txn(0, 16'h1234, 1'b1, 8'hA5, 10, r1);
        @(negedge clk);
        check_eq("wr_grant_latency", r1.g - r1.q, 1);
        check_eq("wr_ack_seen", r1.ack, 1);
        check_eq("wr_ack_pulses", ack_cnt[0] - b_ack[0], 1);
        check_eq("wr_s1_mvalid", mv_cnt[0] - b_mv[0], 0);
        check_eq("wr_s2_mvalid", mv_cnt[1] - b_mv[1], 20);
        check_eq("wr_s3_mvalid", mv_cnt[2] - b_mv[2], 0);
        check_eq("wr_s2_mem", mem[1][12'h234], 8'hA5);

        // Simultaneous reads: m1 from 0x0010 (s1), m2 from 0x2020 (s3).
        b_sv = sv_cnt[1];
        fork
            begin master_txn(0, 16'h0010, 1'b0, 8'h00, 10, r1); sv_mid = sv_cnt[1] - b_sv; end
            begin master_txn(1, 16'h2020, 1'b0, 8'h00, 10, r2); end
        join
        @(negedge clk);
        check_eq("rd_m1_first", (r1.g < r2.g), 1);
        check_eq("rd_m1_data", r1.rd, 8'h3C);
        check_eq("rd_m1_nbits", r1.nrd, 8);
        check_eq("rd_m2_handover", r2.g, r1.d + 1);
        check_eq("rd_m2_data", r2.rd, 8'hC3);
        check_eq("rd_m2_svalid_quiet", sv_mid, 0);
        check_eq("rd_m2_svalid_total", sv_cnt[1] - b_sv, 8);

        // Device id 3 from m1 with m2 waiting on a write to 0x1001.
        b_ack = ack_cnt; b_mv = mv_cnt;
        fork
            begin
                master_txn(0, 16'h3ABC, 1'b0, 8'h00, 10, r1);
                mv_mid = (mv_cnt[0] - b_mv[0]) + (mv_cnt[1] - b_mv[1]) + (mv_cnt[2] - b_mv[2]);
            end
            begin master_txn(1, 16'h1001, 1'b1, 8'h5A, 10, r2); end
        join
        @(negedge clk);
        check_eq("inv_no_ack", r1.ack, 0);
        check_eq("inv_ack_count", ack_cnt[0] - b_ack[0], 0);
        check_eq("inv_no_mvalid", mv_mid, 0);
        check_eq("inv_m2_handover", r2.g, r1.d + 1);
        check_eq("inv_m2_write", mem[1][12'h001], 8'h5A);

        // m2 writes 0x7F to 0x0456 while m1 reads the same location slightly later.
        fork
            begin master_txn(1, 16'h0456, 1'b1, 8'h7F, 10, r2); end
            begin repeat (2) @(posedge clk); master_txn(0, 16'h0456, 1'b0, 8'h00, 10, r1); end
        join
        @(negedge clk);
        check_eq("raw_m1_after_m2", r1.g, r2.d + 1);
        check_eq("raw_m1_data", r1.rd, 8'h7F);

        // Busy s1 withholds ack; then reset mid-transfer.
        s_ready[0] = 1'b0;
        b_ack = ack_cnt;
        rise_cyc = -1;
        fork
            begin master_txn(0, 16'h0010, 1'b0, 8'h00, 60, r1); end
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                check_eq("busy_ack_withheld", ack_cnt[0] - b_ack[0], 0);
                #1;
                s_ready[0] = 1'b1;
                rise_cyc = cyc;
                repeat (3) @(posedge clk);
                #3;
                check_eq("busy_fwd_before_rst", s_mvalid[0], 1);
                rst = 1'b1;
                #1;
                check_eq("rst_grant_cleared", m_bgrant, 0);
                check_eq("rst_select_cleared", {s_mvalid, s_wdata, m_svalid}, 0);
            end
        join
        check_eq("busy_ack_cycle", ack_cyc[0], rise_cyc + 1);
        check_eq("busy_ack_pulses", ack_cnt[0] - b_ack[0], 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_m2s3_interconnect.md
Name:
bus_m2s3_interconnect

Overview:
Serial 1-bit system-bus interconnect joining two master_port instances to three slave instances. It contains a request/grant arbiter, a serial device-address decoder, and the master-to-slave and slave-to-master signal muxes. All data, address and mode traffic is bit-serial, LSB first.

Parameters:
ADDR_WIDTH, 16, full bus address width (device field plus slave memory address).
DATA_WIDTH, 8, data word width in bits.
SLAVE_MEM_ADDR_WIDTH, 12, slave-local address width. DEVICE_ADDR_WIDTH = ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH is a derived localparam, 4 by default.

Ports:
clk  input  1  system clock; all state is updated on its rising edge.
rst  input  1  asynchronous, active-high reset.
mN_wdata (N=1,2)  input  1  serial address/write data from master N.
mN_mode  input  1  from master N: 0 = read, 1 = write.
mN_mvalid  input  1  master N serial bit valid.
mN_breq  input  1  master N bus request; held high for the whole transaction.
mN_bgrant  output  1  bus granted to master N.
mN_ack  output  1  one-cycle pulse: address accepted, slave connected.
mN_rdata  output  1  serial read data to master N.
mN_svalid  output  1  read data bit valid to master N.
sK_wdata (K=1,2,3)  output  1  serial address/write data to slave K.
sK_mode  output  1  mode forwarded to slave K.
sK_mvalid  output  1  bit valid forwarded to slave K.
sK_rdata  input  1  serial read data from slave K.
sK_svalid  input  1  read data bit valid from slave K.
sK_ready  input  1  slave K idle and able to accept a transaction.

Behaviour:
- Reset (asynchronous, rst=1): every output is 0, arbiter is IDLE, decoder is IDLE, no slave is selected. Reset asserted mid-transaction aborts the transaction immediately.
- Arbiter states are IDLE, M1, M2; the grant is registered. From IDLE, a request is granted on the next edge; m1 wins when both request in the same cycle (fixed priority).
- Grant is held while the owner keeps breq high. When the owner drops breq, the grant is re-evaluated on the following edge, so a waiting master is granted with no idle cycle.
- Decoder states are IDLE, ADDR, CHECK, WAIT_RDY, CONNECT, INVALID.
- ADDR: the granted master's first DEVICE_ADDR_WIDTH bits with mvalid=1 are shifted into dev_addr, LSB first. These address bits are not forwarded to any slave.
- CHECK: slave id = dev_addr[1:0]. The address is valid only if dev_addr[3:2]==0 and id!=3; id 0 maps to s1, 1 to s2, 2 to s3.
- Valid address with sK_ready=1: ack is pulsed for exactly one cycle to the granted master and the decoder enters CONNECT.
- Valid address with sK_ready=0: the decoder waits in WAIT_RDY, then acks once ready is high.
- Invalid address: no ack is issued; the decoder enters INVALID, all slave outputs stay 0, and it remains there until the owner drops breq.
- CONNECT: the granted master's wdata, mode and mvalid drive the selected slave combinationally, carrying SLAVE_MEM_ADDR_WIDTH address bits and then DATA_WIDTH write bits. The selected slave's rdata/svalid drive the granted master's rdata/svalid combinationally.
- Unselected slaves and the non-granted master see 0 on every forwarded line.
- Transaction end: owner breq falling clears the selection and returns the decoder to IDLE on the next edge.
- There is no timeout and no retry inside the bus; master_port owns abort on a missing ack.

Decomposition:
- Shared package holds the slave-id encodings, the decoder state enum, and a DEVICE_ADDR_WIDTH helper.
- Natural sub-module: bus_addr_decoder (shift register, CHECK and ready wait, slave select, ack). The arbiter and the muxes stay in the top module.

Test Plan:
- Reset then idle: with rst=1, all outputs are 0. After release with no requests, bgrant stays 0 for 10 cycles.
- m1 write to 0x1234 (id 1) with data 0xA5: m1_bgrant is 1 one cycle after breq; m1_ack pulses once after the 4 device bits; only slave2 sees mvalid; slave2 memory[0x234]==0xA5.
- Simultaneous m1 and m2 reads of 0x0010 and 0x2020: m1 is served first and m2 is granted the cycle after m1_breq drops. Each master receives its own slave's 8 read bits; m2_svalid stays 0 during m1's transfer.
- Device id 3 (address 0x3ABC): no ack, all sK_mvalid stay 0; after m1 drops breq, a pending m2 request is granted.
- m2 writes 0x7F to 0x0456 while m1 issues a delayed read of 0x0456: the write completes first and m1 reads 0x7F.
- Slave busy (s1_ready=0) at CHECK: ack is withheld and issued one cycle after s1_ready rises. Asserting rst mid-transfer clears the grant and select immediately.
